instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 69 ++++++
 tb/tb_instr_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetcher with a 2-entry buffer, redirect flush, halt detect and immediate override
module instr_fetch #(
   parameter logic [7:0]  RESET_PC  = 8'h00,
   parameter logic [31:0] HALT_WORD = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_en,
   output logic [7:0]  mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [7:0]  redirect_pc,
   input  logic        imm_override,
   input  logic [11:0] imm_sw,
   output logic [31:0] instr,
   output logic [7:0]  instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        halted,
   output logic [1:0]  fifo_count
);
   logic [7:0]  fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d, mem_addr_q, mem_addr_d;
   logic        in_flight_q, in_flight_d, halted_q, halted_d;
   logic [1:0]  count_q, count_d, slot;
   logic [39:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic        issue, push, pop;
   always_comb begin
      issue       = !rst && !redirect && !halted_q && !in_flight_q && count_q < 2'd2;
      push        = in_flight_q && !redirect && !halted_q;
      pop         = instr_valid && instr_ready;
      slot        = count_q - {1'b0, pop};
      fetch_pc_d  = redirect ? redirect_pc : fetch_pc_q + {7'd0, issue};
      req_pc_d    = issue ? fetch_pc_q : req_pc_q;
      mem_addr_d  = issue ? fetch_pc_q : mem_addr_q;
      in_flight_d = issue;
      halted_d    = !redirect && (halted_q || (push && mem_rdata == HALT_WORD));
      count_d     = redirect ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
      ent0_d      = (push && slot == 2'd0) ? {req_pc_q, mem_rdata} : pop ? ent1_q : ent0_q;
      ent1_d      = (push && slot != 2'd0) ? {req_pc_q, mem_rdata} : ent1_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q  <= RESET_PC;
         req_pc_q    <= 8'h00;
         mem_addr_q  <= 8'h00;
         in_flight_q <= 1'b0;
         halted_q    <= 1'b0;
         count_q     <= 2'd0;
         ent0_q      <= 40'd0;
         ent1_q      <= 40'd0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         req_pc_q    <= req_pc_d;
         mem_addr_q  <= mem_addr_d;
         in_flight_q <= in_flight_d;
         halted_q    <= halted_d;
         count_q     <= count_d;
         ent0_q      <= ent0_d;
         ent1_q      <= ent1_d;
      end
   end
   assign mem_en      = issue;
   assign mem_addr    = mem_addr_d;
   assign instr_valid = count_q != 2'd0;
   assign instr_pc    = ent0_q[39:32];
   assign instr       = imm_override ? {imm_sw, ent0_q[19:0]} : ent0_q[31:0];
   assign halted      = halted_q;
   assign fifo_count  = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a queue-based scoreboard checking every transfer
module tb_instr_fetch;
   typedef struct packed {logic [7:0] pc; logic [31:0] w;} ent_t;
   logic        clk = 1'b0, rst = 1'b1;
   logic        mem_en, instr_valid, halted;
   logic [7:0]  mem_addr, instr_pc;
   logic [31:0] mem_rdata = 32'd0, instr;
   logic        redirect = 1'b0, imm_override = 1'b0, instr_ready = 1'b0;
   logic [7:0]  redirect_pc = 8'h00;
   logic [11:0] imm_sw = 12'h000;
   logic [1:0]  fifo_count;
   logic [31:0] store [256];
   ent_t        q[$];
   ent_t        mon_e;
   int          total = 0, bad = 0;

   instr_fetch dut (
      .clk(clk), .rst(rst), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .imm_override(imm_override), .imm_sw(imm_sw),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .halted(halted), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_en) mem_rdata <= store[mem_addr];

   task automatic chk(input string n, input logic [39:0] a, input logic [39:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] pc, input int n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] p;
         p = pc + 8'(i);
         q.push_back({p, store[p]});
      end
   endtask

   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL xfer: unexpected pc %h instr %h, want no transfer", instr_pc, instr);
         end else begin
            mon_e = q.pop_front();
            chk("xfer_pc", 40'(instr_pc), 40'(mon_e.pc));
            chk("xfer_instr", 40'(instr), 40'(mon_e.w));
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) store[i] = 32'h00000013 | (32'(i) << 12);
      store[0] = 32'h00100093; store[1] = 32'h00200113; store[2] = 32'h002081B3; store[3] = 32'h0;
      store[8'h14] = 32'h0;
      store[8'h83] = 32'h0;
      store[8'hFE] = 32'h00500093; store[8'hFF] = 32'h00600113;

      // reset state
      repeat (3) cyc();
      #1;
      chk("rst_mem_en", 40'(mem_en), 40'd0);
      chk("rst_mem_addr", 40'(mem_addr), 40'h00);
      chk("rst_valid", 40'(instr_valid), 40'd0);
      chk("rst_count", 40'(fifo_count), 40'd0);
      chk("rst_halted", 40'(halted), 40'd0);

      // release: fetch 0..3, halt on word 3
      cyc();
      rst = 1'b0; instr_ready = 1'b1;
      push_exp(8'h00, 4);
      #1;
      chk("rel_mem_en0", 40'(mem_en), 40'd1);
      chk("rel_mem_addr0", 40'(mem_addr), 40'h00);
      for (int c = 1; c < 12; c++) begin
         cyc();
         #1;
         chk("rel_mem_en", 40'(mem_en), 40'(c == 2 || c == 4 || c == 6));
         if (c == 2) chk("rel_valid2", 40'(instr_valid), 40'd1);
         if (c == 7) chk("rel_halted7", 40'(halted), 40'd0);
         if (c == 8) chk("rel_halted8", 40'(halted), 40'd1);
      end
      chk("rel_drained", 40'(q.size()), 40'd0);

      // backpressure then drain 0x10..0x14
      cyc();
      redirect = 1'b1; redirect_pc = 8'h10; instr_ready = 1'b0;
      push_exp(8'h10, 5);
      cyc();
      redirect = 1'b0;
      for (int c = 2; c <= 10; c++) begin
         cyc();
         #1;
         if (c >= 6) chk("bp_mem_en", 40'(mem_en), 40'd0);
      end
      chk("bp_count", 40'(fifo_count), 40'd2);
      cyc();
      instr_ready = 1'b1;
      repeat (16) cyc();
      chk("bp_drained", 40'(q.size()), 40'd0);
      chk("bp_halted", 40'(halted), 40'd1);

      // redirect to 0x80 with one entry buffered and a request in flight
      cyc();
      redirect = 1'b1; redirect_pc = 8'h20; instr_ready = 1'b0;
      push_exp(8'h20, 1);
      cyc();
      redirect = 1'b0;
      repeat (3) cyc();
      redirect = 1'b1; redirect_pc = 8'h80; instr_ready = 1'b1;
      #1;
      chk("rd_count_pre", 40'(fifo_count), 40'd1);
      chk("rd_mem_en_pre", 40'(mem_en), 40'd0);
      cyc();
      redirect = 1'b0;
      #1;
      chk("rd_xfer_done", 40'(q.size()), 40'd0);
      push_exp(8'h80, 4);
      chk("rd_valid1", 40'(instr_valid), 40'd0);
      chk("rd_count1", 40'(fifo_count), 40'd0);
      chk("rd_mem_en1", 40'(mem_en), 40'd1);
      chk("rd_mem_addr1", 40'(mem_addr), 40'h80);
      repeat (2) cyc();
      #1;
      chk("rd_valid3", 40'(instr_valid), 40'd1);
      chk("rd_pc3", 40'(instr_pc), 40'h80);
      repeat (12) cyc();
      chk("rd_drained", 40'(q.size()), 40'd0);
      chk("rd_halted", 40'(halted), 40'd1);

      // wrap FE, FF, 00.. and override on the head
      cyc();
      redirect = 1'b1; redirect_pc = 8'hFE; instr_ready = 1'b0;
      push_exp(8'hFE, 6);
      cyc();
      redirect = 1'b0;
      repeat (3) cyc();
      #1;
      chk("ov_valid", 40'(instr_valid), 40'd1);
      chk("ov_pc", 40'(instr_pc), 40'hFE);
      imm_override = 1'b1; imm_sw = 12'hABC;
      #1;
      chk("ov_on", 40'(instr), 40'hABC00093);
      imm_override = 1'b0;
      #1;
      chk("ov_off", 40'(instr), 40'h00500093);
      instr_ready = 1'b1;
      repeat (16) cyc();
      chk("wrap_drained", 40'(q.size()), 40'd0);
      chk("wrap_halted", 40'(halted), 40'd1);

      // reset mid-stream with a request in flight
      cyc();
      redirect = 1'b1; redirect_pc = 8'h10;
      push_exp(8'h10, 1);
      cyc();
      redirect = 1'b0;
      repeat (3) cyc();
      #1;
      chk("mr_inflight_mem_en", 40'(mem_en), 40'd0);
      rst = 1'b1;
      cyc();
      #1;
      chk("mr_mem_en", 40'(mem_en), 40'd0);
      chk("mr_mem_addr", 40'(mem_addr), 40'h00);
      chk("mr_valid", 40'(instr_valid), 40'd0);
      chk("mr_count", 40'(fifo_count), 40'd0);
      chk("mr_halted", 40'(halted), 40'd0);
      chk("mr_q", 40'(q.size()), 40'd0);
      cyc();
      rst = 1'b0;
      push_exp(8'h00, 4);
      #1;
      chk("mr_rel_mem_en", 40'(mem_en), 40'd1);
      chk("mr_rel_mem_addr", 40'(mem_addr), 40'h00);
      repeat (12) cyc();
      chk("mr_drained", 40'(q.size()), 40'd0);
      chk("mr_halted_end", 40'(halted), 40'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
